// File: rtl/return_stack_pkg.sv
// Shared definitions for the return-address stack: default sizes,
// the {push, pop} command encoding and a width helper for the occupancy count.
package return_stack_pkg;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DEPTH  = 8;

    // Command decoded from the concatenation {push, pop}
    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_POP  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_SWAP = 2'b11
    } cmd_e;

    // The count must be able to hold the value DEPTH itself, hence the extra bit
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/return_stack_stack_mem.sv
// Entry storage for the return stack: a plain register array with one
// synchronous write port and one asynchronous read port, so the top entry
// can reach the PC mux in the same cycle it is addressed.
module stack_mem #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ADDR_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ADDR_W-1:0]        rd_data
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately left unreset since the count masks stale entries
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack for the fetch stage. Push stores a return address,
// pop presents the top entry combinationally for a zero-latency PC redirect.
// Overflow overwrites the oldest entry; status flags are sticky for debug.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ADDR_W-1:0]      pushAddr,
    input  logic                   clrErr,
    output logic [ADDR_W-1:0]      topAddr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int SP_W  = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    cmd_e              cmd;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_next;
    logic [SP_W-1:0]   sp_top;
    logic [SP_W-1:0]   wr_addr;
    logic [CNT_W-1:0]  count_next;
    logic              wr_en;
    logic              mem_we;
    logic              set_over;
    logic              set_under;
    logic              is_empty;
    logic              is_full;
    logic [ADDR_W-1:0] rd_data;

    assign cmd      = cmd_e'({push, pop});
    assign sp_top   = sp - SP_W'(1);
    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_W'(DEPTH));
    assign empty    = is_empty;
    assign full     = is_full;
    assign topAddr  = is_empty ? '0 : rd_data;
    assign mem_we   = wr_en & ~rst;

    // Decode the command into the next pointer/count, the write request and flag set events
    always_comb begin
        sp_next    = sp;
        count_next = count;
        wr_en      = 1'b0;
        wr_addr    = sp;
        set_over   = 1'b0;
        set_under  = 1'b0;
        case (cmd)
            CMD_PUSH: begin
                wr_en   = 1'b1;
                wr_addr = sp;
                sp_next = sp + SP_W'(1);
                if (is_full) begin
                    set_over = 1'b1;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            CMD_POP: begin
                if (is_empty) begin
                    set_under = 1'b1;
                end else begin
                    sp_next    = sp_top;
                    count_next = count - CNT_W'(1);
                end
            end
            CMD_SWAP: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    wr_addr    = sp;
                    sp_next    = sp + SP_W'(1);
                    count_next = CNT_W'(1);
                    set_under  = 1'b1;
                end else begin
                    wr_addr = sp_top;
                end
            end
            default: begin
            end
        endcase
    end

    // Pointer, occupancy and sticky flags; a set event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            count     <= count_next;
            overflow  <= set_over  | (overflow  & ~clrErr);
            underflow <= set_under | (underflow & ~clrErr);
        end
    end

    stack_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (pushAddr),
        .rd_addr (sp_top),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack. The driver applies one command per
// cycle and queues the outputs expected during that cycle; a monitor pops
// and compares on every falling edge.
module tb_return_stack;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pushAddr;
    logic              clrErr;
    logic [ADDR_W-1:0] topAddr;
    logic              empty;
    logic              full;
    logic [3:0]        count;
    logic              overflow;
    logic              underflow;

    typedef struct {
        string       name;
        logic [11:0] top;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .pushAddr  (pushAddr),
        .clrErr    (clrErr),
        .topAddr   (topAddr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Drive one command just after the rising edge and queue the outputs expected before the next edge
    task automatic apply_stimulus(input logic p, input logic q, input logic [11:0] a,
                                  input logic c, input logic r, input string name,
                                  input logic [11:0] e_top, input int e_cnt,
                                  input logic e_ovf, input logic e_unf);
        exp_t e;
        @(posedge clk);
        #1;
        push     = p;
        pop      = q;
        pushAddr = a;
        clrErr   = c;
        rst      = r;
        e.name   = name;
        e.top    = e_top;
        e.cnt    = 4'(e_cnt);
        e.ovf    = e_ovf;
        e.unf    = e_unf;
        exp_q.push_back(e);
    endtask

    // Compare every output against one expected record
    task automatic check_output(input exp_t e);
        logic e_empty;
        logic e_full;
        e_empty = (e.cnt == 4'd0);
        e_full  = (e.cnt == 4'd8);
        n_checks++;
        if (topAddr !== e.top || count !== e.cnt || empty !== e_empty || full !== e_full ||
            overflow !== e.ovf || underflow !== e.unf) begin
            n_fail++;
            $display("[TB] FAIL %s: got top=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b, expected top=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b",
                     e.name, topAddr, count, empty, full, overflow, underflow,
                     e.top, e.cnt, e_empty, e_full, e.ovf, e.unf);
        end
    endtask

    // Monitor: one expected record per driven cycle, checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check_output(exp_q.pop_front());
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        rst      = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        pushAddr = '0;
        clrErr   = 1'b0;
        repeat (2) @(posedge clk);

        // reset state, LIFO order and zero-latency pop read
        apply_stimulus(0, 0, 12'h000, 0, 0, "reset",       12'h000, 0, 0, 0);
        apply_stimulus(1, 0, 12'h010, 0, 0, "push_010",    12'h000, 0, 0, 0);
        apply_stimulus(1, 0, 12'h020, 0, 0, "push_020",    12'h010, 1, 0, 0);
        apply_stimulus(1, 0, 12'h030, 0, 0, "push_030",    12'h020, 2, 0, 0);
        apply_stimulus(0, 1, 12'h000, 0, 0, "pop_030",     12'h030, 3, 0, 0);
        apply_stimulus(0, 1, 12'h000, 0, 0, "pop_020",     12'h020, 2, 0, 0);
        apply_stimulus(0, 1, 12'h000, 0, 0, "pop_010",     12'h010, 1, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "drained",     12'h000, 0, 0, 0);

        // underflow and its clear
        apply_stimulus(0, 1, 12'h000, 0, 0, "pop_empty",   12'h000, 0, 0, 0);
        apply_stimulus(0, 0, 12'h000, 1, 0, "unf_set",     12'h000, 0, 0, 1);
        apply_stimulus(0, 0, 12'h000, 0, 0, "unf_clr",     12'h000, 0, 0, 0);

        // nine pushes into eight entries: oldest lost, overflow set
        for (int k = 1; k <= 9; k++) begin
            apply_stimulus(1, 0, 12'(k), 0, 0, "fill9",
                           (k == 1) ? 12'h000 : 12'(k - 1), k - 1, 0, 0);
        end
        for (int j = 0; j < 8; j++) begin
            apply_stimulus(0, 1, 12'h000, 0, 0, "drain8", 12'(9 - j), 8 - j, 1, 0);
        end
        apply_stimulus(0, 0, 12'h000, 1, 0, "ovf_set",     12'h000, 0, 1, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "ovf_clr",     12'h000, 0, 0, 0);

        // swap replaces the top, second entry untouched
        apply_stimulus(1, 0, 12'h033, 0, 0, "push_033",    12'h000, 0, 0, 0);
        apply_stimulus(1, 0, 12'h044, 0, 0, "push_044",    12'h033, 1, 0, 0);
        apply_stimulus(1, 1, 12'h0AB, 0, 0, "swap_0ab",    12'h044, 2, 0, 0);
        apply_stimulus(0, 1, 12'h000, 0, 0, "after_swap",  12'h0AB, 2, 0, 0);
        apply_stimulus(0, 1, 12'h000, 0, 0, "second",      12'h033, 1, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "swap_done",   12'h000, 0, 0, 0);

        // reset overrides a simultaneous push
        apply_stimulus(1, 0, 12'h100, 0, 0, "push_100",    12'h000, 0, 0, 0);
        apply_stimulus(1, 0, 12'h200, 0, 0, "push_200",    12'h100, 1, 0, 0);
        apply_stimulus(1, 0, 12'h300, 0, 1, "rst_push",    12'h200, 2, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "after_rst",   12'h000, 0, 0, 0);
        apply_stimulus(1, 0, 12'h055, 0, 0, "push_055",    12'h000, 0, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "top_055",     12'h055, 1, 0, 0);
        apply_stimulus(0, 1, 12'h000, 0, 0, "pop_055",     12'h055, 1, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "rst_done",    12'h000, 0, 0, 0);

        // swap on empty acts as push and flags underflow
        apply_stimulus(1, 1, 12'h077, 0, 0, "swap_empty",  12'h000, 0, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "swapE_state", 12'h077, 1, 0, 1);
        apply_stimulus(0, 0, 12'h000, 1, 0, "swapE_clr",   12'h077, 1, 0, 1);
        apply_stimulus(0, 1, 12'h000, 0, 0, "swapE_pop",   12'h077, 1, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "swapE_done",  12'h000, 0, 0, 0);

        // set beats a coincident clear
        apply_stimulus(0, 1, 12'h000, 1, 0, "pop_clr",     12'h000, 0, 0, 0);
        apply_stimulus(0, 0, 12'h000, 0, 0, "set_wins",    12'h000, 0, 0, 1);
        apply_stimulus(0, 0, 12'h000, 1, 0, "late_clr",    12'h000, 0, 0, 1);
        apply_stimulus(0, 0, 12'h000, 0, 0, "late_clr2",   12'h000, 0, 0, 0);

        // advance the pointer base to 7 so the alternation below wraps sp
        for (int k = 1; k <= 15; k++) begin
            apply_stimulus(1, 0, 12'(12'h0D0 + k), 0, 0, "prefill",
                           (k == 1) ? 12'h000 : 12'(12'h0D0 + k - 1),
                           (k - 1 > 8) ? 8 : k - 1, (k >= 10) ? 1'b1 : 1'b0, 0);
        end
        for (int j = 0; j < 8; j++) begin
            apply_stimulus(0, 1, 12'h000, 0, 0, "predrain", 12'(12'h0DF - j), 8 - j, 1, 0);
        end
        apply_stimulus(0, 0, 12'h000, 1, 0, "pre_clr",     12'h000, 0, 1, 0);

        // back-to-back push/pop across the wrap
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                apply_stimulus(1, 0, 12'(12'h0C0 + i), 0, 0, "alt_push", 12'h000, 0, 0, 0);
            end else begin
                apply_stimulus(0, 1, 12'h000, 0, 0, "alt_pop", 12'(12'h0C0 + i - 1), 1, 0, 0);
            end
        end
        apply_stimulus(0, 0, 12'h000, 0, 0, "final",       12'h000, 0, 0, 0);

        @(posedge clk);
        #1;
        push   = 1'b0;
        pop    = 1'b0;
        clrErr = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d unchecked records, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
